// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 request arbiter: opcodes, capture status codes,
// client ids and the per-client capture classification helper.
package ats21_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'b000,
        OP_SET_CLK   = 3'b001,
        OP_TOG_BC    = 3'b010,
        OP_MODE      = 3'b011,
        OP_ILLEGAL   = 3'b100,
        OP_ALARM     = 3'b101,
        OP_COUNTDOWN = 3'b110,
        OP_TOG_AT    = 3'b111
    } ats21_op_e;

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } ats21_client_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CAPT = 1'b1
    } ats21_cap_state_e;

    // Codes are ordered so that the numerically larger code wins when merging clients.
    localparam logic [1:0] STAT_NONE    = 2'b00;
    localparam logic [1:0] STAT_ACCEPT  = 2'b01;
    localparam logic [1:0] STAT_DROP    = 2'b10;
    localparam logic [1:0] STAT_ILLEGAL = 2'b11;

    function automatic logic [1:0] capture_result(input ats21_op_e op, input logic can_write);
        if (op == OP_NOP)
            return STAT_NONE;
        else if (op == OP_ILLEGAL)
            return STAT_ILLEGAL;
        else if (can_write)
            return STAT_ACCEPT;
        else
            return STAT_DROP;
    endfunction

endpackage

// File: rtl/ats21_req_arbiter_if.sv
// Capture-side and command-side signals of the ATS21 request arbiter.
// slave = the arbiter, master = the block driving instructions and accepting commands.
interface ats21_req_arbiter_if;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready;
    logic [1:0]  stat;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_client;
    logic [31:0] cmd_word;

    modport master (
        output req, ctrlA, ctrlB, cmd_ready,
        input  ready, stat, cmd_valid, cmd_client, cmd_word
    );

    modport slave (
        input  req, ctrlA, ctrlB, cmd_ready,
        output ready, stat, cmd_valid, cmd_client, cmd_word
    );
endinterface

// File: rtl/ats21_rr_arb.sv
// Two-way grant logic with a round-robin pointer; the grant is frozen while a
// presented command is stalled. Define ATS_ARB_FIXED_PRIO_EN to make client A always win.
module ats21_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       ack,
    output logic [1:0] grant
);
    logic [1:0] pick;
    logic [1:0] grant_q;
    logic       lock_q;

`ifdef ATS_ARB_FIXED_PRIO_EN
    always_comb begin
        pick = (req == 2'b11) ? 2'b01 : req;
    end
`else
    logic ptr_q;

    always_comb begin
        pick = req;
        if (req == 2'b11)
            pick = ptr_q ? 2'b10 : 2'b01;
    end

    // After serving A the pointer prefers B, and vice versa.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= 1'b0;
        else if ((|grant) && ack)
            ptr_q <= grant[0];
    end
`endif

    assign grant = lock_q ? grant_q : pick;

    // NOTE: state uses <= so every flop samples pre-edge values; comb blocks assign defaults first to avoid latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= 2'b00;
            lock_q  <= 1'b0;
        end else begin
            grant_q <= grant;
            lock_q  <= (|grant) && !ack;
        end
    end
endmodule

// File: rtl/ats21_req_arbiter.sv
// ATS21 request arbiter: two-phase capture of A/B instructions into 1-deep
// client buffers, then arbitration onto a valid/ready command port (see ats21_rr_arb).
module ats21_req_arbiter (
    input logic                 clk,
    input logic                 reset,
    ats21_req_arbiter_if.slave  bus
);
    import ats21_pkg::*;

    ats21_cap_state_e  state_q, state_d;
    logic              upper_en;
    logic              commit;

    logic [1:0][15:0]  ctrl_now;
    logic [1:0][15:0]  upper_q;
    logic [1:0]        full_q;
    logic [1:0][31:0]  buf_q;
    logic [1:0]        grant;
    logic [1:0]        issue;
    logic [1:0][1:0]   res;
    logic [1:0]        stat_d;
    logic [1:0]        stat_q;

    assign ctrl_now = {bus.ctrlB, bus.ctrlA};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req) state_d = ST_CAPT;
            ST_CAPT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        upper_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            ST_IDLE: upper_en = bus.req;
            ST_CAPT: commit   = 1'b1;
            default: ;
        endcase
    end

    // NOTE: pure data registers carry no reset; the valid/full flags guarding them do.
    always_ff @(posedge clk) begin
        if (upper_en)
            upper_q <= ctrl_now;
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            issue[c] = grant[c] && bus.cmd_ready;
            res[c]   = capture_result(ats21_op_e'(upper_q[c][15:13]), !full_q[c] || issue[c]);
        end
        stat_d = STAT_NONE;
        if (commit)
            stat_d = (res[0] > res[1]) ? res[0] : res[1];
    end

    // A buffer being issued on the commit edge takes the new instruction in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 2'b00;
            stat_q <= STAT_NONE;
        end else begin
            stat_q <= stat_d;
            for (int c = 0; c < 2; c++) begin
                if (commit && res[c] == STAT_ACCEPT)
                    full_q[c] <= 1'b1;
                else if (issue[c])
                    full_q[c] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (commit && res[c] == STAT_ACCEPT)
                buf_q[c] <= {upper_q[c], ctrl_now[c]};
        end
    end

    ats21_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (full_q),
        .ack   (bus.cmd_ready),
        .grant (grant)
    );

    assign bus.cmd_valid  = |grant;
    assign bus.cmd_client = grant[1];
    assign bus.cmd_word   = grant[1] ? buf_q[1] : (grant[0] ? buf_q[0] : 32'h0);
    assign bus.stat       = stat_q;
    assign bus.ready      = (state_q == ST_IDLE) && (full_q == 2'b00);
endmodule

// File: tb/tb_ats21_req_arbiter.sv
// Directed bench for ats21_req_arbiter: a table of single-capture vectors plus
// hand-written sequences for drop, alternation, reset-in-CAPT and held req.
module tb_ats21_req_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ats21_req_arbiter_if bus ();

    ats21_req_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  stat;
        logic        valid;
        logic        client;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req = 1'b0;
        bus.ctrlA = 16'h0;
        bus.ctrlB = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns in the cycle after the CAPT->IDLE edge.
    task automatic capture(input logic [31:0] a, input logic [31:0] b);
        bus.req = 1'b1;
        bus.ctrlA = a[31:16];
        bus.ctrlB = b[31:16];
        @(negedge clk);
        bus.req = 1'b0;
        bus.ctrlA = a[15:0];
        bus.ctrlB = b[15:0];
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h2000_0000, 32'h2240_0000, 2'b01, 1'b1, 1'b0, 32'h2000_0000};
        vecs[1] = '{32'h8000_0000, 32'h0000_0000, 2'b11, 1'b0, 1'b0, 32'h0000_0000};
        vecs[2] = '{32'h0000_0000, 32'h6000_1234, 2'b01, 1'b1, 1'b1, 32'h6000_1234};
        vecs[3] = '{32'h8000_0000, 32'h4000_0001, 2'b11, 1'b1, 1'b1, 32'h4000_0001};
        vecs[4] = '{32'h0000_0000, 32'h0000_0000, 2'b00, 1'b0, 1'b0, 32'h0000_0000};
        vecs[5] = '{32'h0000_FFFF, 32'h8FFF_0000, 2'b11, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6] = '{32'hE000_00FF, 32'h0000_0000, 2'b01, 1'b1, 1'b0, 32'hE000_00FF};

        bus.cmd_ready = 1'b0;
        do_reset();
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset stat", 32'(bus.stat), 32'd0);
        check("reset cmd_valid", 32'(bus.cmd_valid), 32'd0);
        check("reset cmd_client", 32'(bus.cmd_client), 32'd0);
        check("reset cmd_word", bus.cmd_word, 32'h0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            capture(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d stat", i), 32'(bus.stat), 32'(vecs[i].stat));
            check($sformatf("vec%0d valid", i), 32'(bus.cmd_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d client", i), 32'(bus.cmd_client), 32'(vecs[i].client));
            check($sformatf("vec%0d word", i), bus.cmd_word, vecs[i].word);
            @(negedge clk);
            check($sformatf("vec%0d stat pulse", i), 32'(bus.stat), 32'd0);
            check($sformatf("vec%0d valid held", i), 32'(bus.cmd_valid), 32'(vecs[i].valid));
        end

        // Both clients in one req, sink always ready: A then B, then idle.
        do_reset();
        bus.cmd_ready = 1'b1;
        capture(32'h2000_0000, 32'h2240_0000);
        check("ab stat", 32'(bus.stat), 32'd1);
        check("ab first client", 32'(bus.cmd_client), 32'd0);
        check("ab first word", bus.cmd_word, 32'h2000_0000);
        check("ab ready busy", 32'(bus.ready), 32'd0);
        @(negedge clk);
        check("ab second valid", 32'(bus.cmd_valid), 32'd1);
        check("ab second client", 32'(bus.cmd_client), 32'd1);
        check("ab second word", bus.cmd_word, 32'h2240_0000);
        @(negedge clk);
        check("ab drained valid", 32'(bus.cmd_valid), 32'd0);
        check("ab ready", 32'(bus.ready), 32'd1);

        // Full buffer drops a second instruction; the held one issues exactly once.
        do_reset();
        bus.cmd_ready = 1'b0;
        capture(32'hA000_0190, 32'h0);
        check("drop first stat", 32'(bus.stat), 32'd1);
        capture(32'hA000_0190, 32'h0);
        check("drop second stat", 32'(bus.stat), 32'd2);
        check("drop held word", bus.cmd_word, 32'hA000_0190);
        check("drop held valid", 32'(bus.cmd_valid), 32'd1);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        check("drop issued once", 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        check("drop stays empty", 32'(bus.cmd_valid), 32'd0);
        check("drop ready", 32'(bus.ready), 32'd1);

        // Both full; A refilled on the edge it issues, then grants follow the policy.
        do_reset();
        bus.cmd_ready = 1'b0;
        capture(32'h2000_0001, 32'h4000_0002);
        check("alt fill stat", 32'(bus.stat), 32'd1);
        bus.req = 1'b1;
        bus.ctrlA = 16'h3000;
        bus.ctrlB = 16'h0000;
        @(negedge clk);
        bus.req = 1'b0;
        bus.ctrlA = 16'h0003;
        check("alt grant0 client", 32'(bus.cmd_client), 32'd0);
        check("alt grant0 word", bus.cmd_word, 32'h2000_0001);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        check("alt refill stat", 32'(bus.stat), 32'd1);
`ifdef ATS_ARB_FIXED_PRIO_EN
        check("alt grant1 client", 32'(bus.cmd_client), 32'd0);
        check("alt grant1 word", bus.cmd_word, 32'h3000_0003);
        @(negedge clk);
        check("alt grant2 client", 32'(bus.cmd_client), 32'd1);
        check("alt grant2 word", bus.cmd_word, 32'h4000_0002);
`else
        check("alt grant1 client", 32'(bus.cmd_client), 32'd1);
        check("alt grant1 word", bus.cmd_word, 32'h4000_0002);
        @(negedge clk);
        check("alt grant2 client", 32'(bus.cmd_client), 32'd0);
        check("alt grant2 word", bus.cmd_word, 32'h3000_0003);
`endif
        @(negedge clk);
        check("alt drained", 32'(bus.cmd_valid), 32'd0);
        bus.cmd_ready = 1'b0;

        // Reset landing in CAPT discards the half-captured instruction.
        do_reset();
        bus.cmd_ready = 1'b1;
        bus.req = 1'b1;
        bus.ctrlA = 16'h2000;
        bus.ctrlB = 16'h6000;
        @(posedge clk);
        #2;
        reset = 1'b1;
        bus.req = 1'b0;
        bus.ctrlA = 16'h0005;
        bus.ctrlB = 16'h0006;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rstcapt stat c%0d", k), 32'(bus.stat), 32'd0);
            check($sformatf("rstcapt valid c%0d", k), 32'(bus.cmd_valid), 32'd0);
            check($sformatf("rstcapt ready c%0d", k), 32'(bus.ready), 32'd1);
        end

        // req held for two cycles: the second sample lands in CAPT and is ignored.
        bus.req = 1'b1;
        bus.ctrlA = 16'h2000;
        bus.ctrlB = 16'h0000;
        @(negedge clk);
        bus.ctrlA = 16'h0007;
        @(negedge clk);
        bus.req = 1'b0;
        check("hold stat", 32'(bus.stat), 32'd1);
        check("hold word", bus.cmd_word, 32'h2000_0007);
        @(negedge clk);
        check("hold stat once", 32'(bus.stat), 32'd0);
        check("hold single issue", 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        check("hold no second stat", 32'(bus.stat), 32'd0);
        check("hold ready", 32'(bus.ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ats21_req_arbiter.md
ATS21_REQ_ARBITER -- requirements
Module: ats21_req_arbiter

Interface
REQ-001 Ports: clk  in  1  system clock, all state on posedge; reset  in  1  asynchronous, active-high.
REQ-002 Port: req  in  1  instruction strobe; high for one cycle, marks the first (upper) word on ctrlA/ctrlB.
REQ-003 Ports: ctrlA  in  16  client A instruction half-word; ctrlB  in  16  client B instruction half-word.
REQ-004 Port: ready  out  1  high when the capture FSM is IDLE and both client buffers are empty.
REQ-005 Port: stat  out  2  capture result, valid for one cycle: 00 none, 01 accepted, 10 dropped (buffer full), 11 illegal opcode.
REQ-006 Ports: cmd_valid  out  1;  cmd_ready  in  1;  cmd_client  out  1 (0=A, 1=B);  cmd_word  out  32  {upper, lower} instruction to the ATS21 core.

Function
REQ-007 The capture FSM SHALL have states IDLE and CAPT: IDLE->CAPT when req=1 (upper halves of ctrlA/ctrlB latched on that edge); CAPT->IDLE unconditionally (lower halves latched on that edge).
REQ-008 req sampled in CAPT SHALL be ignored; no state change beyond CAPT->IDLE.
REQ-009 A client whose upper opcode [15:13] is 000 SHALL be treated as not requesting; nothing buffered, no stat contribution.
REQ-010 Opcode 100 SHALL be illegal: instruction discarded, stat=11.
REQ-011 Each client SHALL own a 1-deep buffer; legal instruction written on the CAPT->IDLE edge if empty, or if being issued (cmd_valid&cmd_ready for that client) on the same edge.
REQ-012 A legal instruction arriving at a full, non-draining buffer SHALL be dropped (stat=10); the other client is unaffected.
REQ-013 stat SHALL be registered, asserted only in the cycle after the CAPT->IDLE edge, priority 11 > 10 > 01 across both clients, 00 otherwise.
REQ-014 Latency: req sampled at edge N -> cmd_valid high in the cycle after edge N+1 (earliest).
REQ-015 cmd_valid/cmd_client/cmd_word SHALL be held stable until cmd_valid&cmd_ready; transfer on that edge frees the buffer.
REQ-016 Arbitration SHALL be 2-way round-robin: pointer moves to the other client after each transfer; single requester granted immediately.
REQ-017 Grant SHALL change only when no transfer is pending (no switching while cmd_valid high and cmd_ready low).

Reset
REQ-018 reset SHALL asynchronously force FSM=IDLE, both buffers empty, RR pointer=A, stat=00, cmd_valid=0, cmd_client=0, cmd_word=0, ready=1 after release.
REQ-019 reset during CAPT SHALL discard the partial instruction; no stat pulse after release.

Configuration
REQ-020 With ATS_ARB_FIXED_PRIO_EN defined, client A SHALL always win when both buffers are full; without it, round-robin per REQ-016.

Structure
REQ-021 Package ats21_pkg SHALL hold the opcode enum (NOP 000, SET_CLK 001, TOG_BC 010, MODE 011, ILLEGAL 100, ALARM 101, COUNTDOWN 110, TOG_AT 111), stat code constants, client enum.
REQ-022 The grant logic SHALL be a sub-module ats21_rr_arb (2 requests, 1-hot grant, pointer, macro-controlled priority).

Verification
REQ-023 A=0x2000_0000, B=0x2240_0000 in one req, cmd_ready=1 -> stat=01; A issued, then B on next cycle; ready=1 afterwards.
REQ-024 cmd_ready=0, send A=0xA000_0190 twice -> second capture stat=10, buffer still 0xA000_0190; then cmd_ready=1 issues it once.
REQ-025 A=0x8000_0000, B=0x0000_0000 -> stat=11, cmd_valid stays 0.
REQ-026 Both buffers full, cmd_ready toggled 1 -> grants alternate A,B,A (macro off); A,A first when ATS_ARB_FIXED_PRIO_EN defined and A refilled each time.
REQ-027 reset asserted in CAPT -> cmd_valid=0, stat=00, ready=1 after release; req held high two cycles -> only first captured.
